camera_capture: RTL
===================

CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 The block SHALL have parameter H_PIXELS, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_LINES, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning pixel FIFO entries (power of two, >= 2).
REQ-004 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port piul1Clock, input, 1 bit: system clock (50 MHz).
REQ-006 The block SHALL have port piul1Reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port piul1Enable, input, 1 bit: capture enable, level.
REQ-008 The block SHALL have port piul1CamVsync, input, 1 bit: camera frame sync, active-high, synchronised upstream.
REQ-009 The block SHALL have port piul1CamHref, input, 1 bit: camera line-valid, active-high.
REQ-010 The block SHALL have port piul1CamStrobe, input, 1 bit: one-cycle byte-valid pulse.
REQ-011 The block SHALL have port piulCamData, input, 8 bits: camera byte, RGB565, high byte first.
REQ-012 The block SHALL have port poul1FrmValid, output, 1 bit: frame-transfer pixel valid.
REQ-013 The block SHALL have port piul1FrmReady, input, 1 bit: frame-transfer sink ready.
REQ-014 The block SHALL have port poul1FrmSof, output, 1 bit: pixel is (0,0).
REQ-015 The block SHALL have port poul1FrmEol, output, 1 bit: pixel is last of a line.
REQ-016 The block SHALL have port poulFrmPixel, output, 16 bits: RGB565 pixel.
REQ-017 The block SHALL have port poul1Overflow, output, 1 bit: sticky, FIFO write dropped.
REQ-018 The block SHALL have port poul1SizeError, output, 1 bit: sticky, frame geometry mismatch.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, WAIT_FRAME, CAPTURE and FLUSH.
REQ-020 IDLE SHALL go to WAIT_FRAME when piul1Enable=1.
REQ-021 WAIT_FRAME SHALL go to CAPTURE on a piul1CamVsync falling edge, where edge detection uses a registered copy of Vsync.
REQ-022 CAPTURE SHALL go to FLUSH on a Vsync rising edge.
REQ-023 FLUSH SHALL go to WAIT_FRAME (Enable=1) or IDLE (Enable=0) once the FIFO is empty; a capture in progress always completes its frame.
REQ-024 In CAPTURE, a strobe with Href=1 SHALL toggle a byte phase: phase 0 latches the high byte; phase 1 forms the pixel {high,low} and writes it to the FIFO in the same cycle.
REQ-025 The byte phase SHALL clear on Href falling edge and on leaving CAPTURE; odd trailing bytes are discarded.
REQ-026 The column counter SHALL run 0..H_PIXELS-1 per written pixel.
REQ-027 The row counter SHALL increment on Href falling edge when the column counter is nonzero.
REQ-028 Sof SHALL be stored with a pixel when row=0 and col=0; Eol SHALL be stored when col=H_PIXELS-1.
REQ-029 Pixels with col>=H_PIXELS or row>=V_LINES SHALL NOT be written and SHALL set poul1SizeError.
REQ-030 At Vsync rising edge, row!=V_LINES SHALL set poul1SizeError.
REQ-031 A line ending with col!=H_PIXELS (nonzero) SHALL set poul1SizeError.
REQ-032 The FIFO SHALL be first-word-fall-through, storing {Sof,Eol,pixel} (18 bits).
REQ-033 Valid SHALL equal not-empty.
REQ-034 A pop SHALL occur on Valid&&Ready; Valid, Sof, Eol and pixel SHALL hold stable while Valid&&!Ready.
REQ-035 On simultaneous push and pop when full, the push SHALL succeed.
REQ-036 A push when full without a pop SHALL be dropped and SHALL set poul1Overflow; counters advance regardless.
REQ-037 Latency SHALL be 1 cycle from the second-byte strobe to Valid on an empty FIFO.
REQ-038 Sticky flags SHALL clear only on reset or on the WAIT_FRAME->CAPTURE transition.

Reset
REQ-039 Asserting piul1Reset_n=0 SHALL asynchronously force: state IDLE, FIFO empty, counters 0, byte phase 0, Vsync/Href registers 0.
REQ-040 During reset, all outputs SHALL be 0.
REQ-041 Reset mid-frame SHALL discard all buffered pixels, and the block SHALL resynchronise at the next Vsync falling edge.

Structure
REQ-042 A shared package SHALL hold the FSM state enum, the RGB565 pixel typedef, the {Sof,Eol,pixel} FIFO entry struct, and the 640/480 defaults.
REQ-043 The FIFO SHALL be one sub-module, sync_fifo_fwft, parameterised by width and depth.

Verification
REQ-044 Verification SHALL cover: Enable=1, one 640x480 frame of bytes 0x12,0x34 with Ready=1 -> 307200 pixels 0x1234, Sof once, 480 Eol, no flags.
REQ-045 Verification SHALL cover: Ready held 0 after 4 pixels, fifth pixel arrives -> poul1Overflow=1, first 4 pixels output unchanged once Ready=1.
REQ-046 Verification SHALL cover: frame of 479 lines -> poul1SizeError=1 at Vsync rise; cleared at next frame start.
REQ-047 Verification SHALL cover: Href falls after 3 bytes -> one pixel written, third byte dropped, SizeError=1.
REQ-048 Verification SHALL cover: Enable enabled mid-frame -> no output until the following Vsync falling edge; Sof on first pixel.
REQ-049 Verification SHALL cover: reset asserted mid-line with FIFO holding 3 entries -> Valid=0 immediately, asynchronously, and the next frame is captured cleanly.

Source files
------------

// File: rtl/camera_capture_pkg.sv
// camera_capture_pkg: shared FSM state, pixel and FIFO entry types plus default frame geometry
package camera_capture_pkg;
  localparam int H_PIXELS_DEF = 640;
  localparam int V_LINES_DEF = 480;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, FLUSH} state_e;
  typedef logic [15:0] rgb565_t;
  typedef struct packed {
    logic    sof;
    logic    eol;
    rgb565_t pix;
  } fifo_entry_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; push_i/data_i write, data_o shows head, pop_i consumes, empty_o/full_o status
module sync_fifo_fwft #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  // a pop frees the slot being written, so push wins even when full
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/camera_capture.sv
// camera_capture: assembles RGB565 pixels from camera bytes into a FWFT FIFO with Sof/Eol tags
//   camera side: piul1CamVsync/Href/Strobe, piulCamData; stream side: poul1FrmValid/Sof/Eol,
//   poulFrmPixel, piul1FrmReady; sticky status: poul1Overflow, poul1SizeError
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset_n,
  input  logic        piul1Enable,
  input  logic        piul1CamVsync,
  input  logic        piul1CamHref,
  input  logic        piul1CamStrobe,
  input  logic [7:0]  piulCamData,
  output logic        poul1FrmValid,
  input  logic        piul1FrmReady,
  output logic        poul1FrmSof,
  output logic        poul1FrmEol,
  output logic [15:0] poulFrmPixel,
  output logic        poul1Overflow,
  output logic        poul1SizeError
);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int RW = $clog2(V_LINES + 1);
  state_e state_q, state_d;
  logic vsync_q, href_q, phase_q, phase_d, ovf_q, ovf_d, size_q, size_d;
  logic [7:0] hi_q, hi_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic vs_fall, vs_rise, href_fall, in_cap, start, byte_ok, in_range, push, pop, full, empty;
  fifo_entry_t wr_entry, rd_entry;
  assign vs_fall = vsync_q && !piul1CamVsync;
  assign vs_rise = !vsync_q && piul1CamVsync;
  assign href_fall = href_q && !piul1CamHref;
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (piul1Enable) state_d = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) state_d = CAPTURE;
      CAPTURE:    if (vs_rise) state_d = FLUSH;
      FLUSH:      if (empty) state_d = piul1Enable ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    in_cap = state_q == CAPTURE;
    start = (state_q == WAIT_FRAME) && vs_fall;
  end
  assign byte_ok = in_cap && piul1CamStrobe && piul1CamHref;
  assign in_range = (col_q < CW'(H_PIXELS)) && (row_q < RW'(V_LINES));
  assign push = byte_ok && phase_q && in_range;
  assign pop = !empty && piul1FrmReady;
  assign wr_entry = '{sof: (row_q == '0) && (col_q == '0), eol: col_q == CW'(H_PIXELS - 1),
                      pix: {hi_q, piulCamData}};
  always_comb begin
    phase_d = phase_q;
    hi_d = hi_q;
    col_d = col_q;
    row_d = row_q;
    ovf_d = ovf_q;
    size_d = size_q;
    if (start) begin
      phase_d = 1'b0;
      col_d = '0;
      row_d = '0;
      ovf_d = 1'b0;
      size_d = 1'b0;
    end else if (in_cap) begin
      if (byte_ok) begin
        phase_d = !phase_q;
        if (!phase_q) hi_d = piulCamData;
        else if (in_range) col_d = col_q + 1'b1;
        else size_d = 1'b1;
      end
      // rows only count lines that produced pixels; row saturates so overlong frames stay flagged via in_range
      if (href_fall) begin
        phase_d = 1'b0;
        col_d = '0;
        if (col_q != '0) begin
          row_d = (row_q == RW'(V_LINES)) ? row_q : row_q + 1'b1;
          if (col_q != CW'(H_PIXELS)) size_d = 1'b1;
        end
      end
      if (vs_rise) begin
        phase_d = 1'b0;
        if (row_q != RW'(V_LINES)) size_d = 1'b1;
      end
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      phase_q <= 1'b0;
      hi_q <= '0;
      col_q <= '0;
      row_q <= '0;
      ovf_q <= 1'b0;
      size_q <= 1'b0;
    end else begin
      vsync_q <= piul1CamVsync;
      href_q <= piul1CamHref;
      phase_q <= phase_d;
      hi_q <= hi_d;
      col_q <= col_d;
      row_q <= row_d;
      ovf_q <= ovf_d;
      size_q <= size_d;
    end
  end
  sync_fifo_fwft #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(piul1Clock),
    .rst_ni(piul1Reset_n),
    .push_i(push),
    .data_i(wr_entry),
    .pop_i(pop),
    .data_o(rd_entry),
    .empty_o(empty),
    .full_o(full)
  );
  // head entry is gated so every stream output reads 0 whenever nothing is valid
  assign poul1FrmValid = !empty;
  assign poul1FrmSof = !empty && rd_entry.sof;
  assign poul1FrmEol = !empty && rd_entry.eol;
  assign poulFrmPixel = empty ? '0 : rd_entry.pix;
  assign poul1Overflow = ovf_q;
  assign poul1SizeError = size_q;
endmodule
